combo_pipe: RTL and testbench
=============================

COMBO_PIPE -- requirements
Module: combo_pipe

Interface
REQ-001 Parameter N, default 4, SHALL set the number of mux data inputs, encoder inputs and decoder outputs; legal values are powers of two, 2..32.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the transaction counter.
REQ-003 Derived constant W SHALL equal log2(N).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  request present on the input fields this cycle.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 choice  input  2  operation select: 00 mux, 01 encode, 10 decode, 11 isolate-highest.
REQ-009 sel  input  W  mux select index.
REQ-010 mux_in  input  N  mux data bits; bit i is the data for sel=i.
REQ-011 enc_in  input  N  encoder input vector.
REQ-012 dec_in  input  W  decoder input index.
REQ-013 out_valid  output  1  result registers hold an unconsumed result.
REQ-014 out_ready  input  1  downstream accepts the result this cycle.
REQ-015 out_choice  output  2  choice value of the held result.
REQ-016 mux_out  output  1  registered mux result.
REQ-017 enc_out  output  W  registered encoder index.
REQ-018 enc_valid  output  1  registered flag: encoder input had at least one bit set.
REQ-019 dec_out  output  N  registered one-hot result.
REQ-020 txn_count  output  CNT_W  number of results consumed downstream since reset.

Function
REQ-021 Input handshake SHALL be: request accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-022 in_ready SHALL equal (out_valid=0) OR (out_ready=1), combinationally.
REQ-023 An accepted request SHALL load all result outputs and out_choice on the accepting edge, and set out_valid=1; latency is exactly one cycle.
REQ-024 Output handshake SHALL be: result consumed on an edge where out_valid=1 and out_ready=1.
REQ-025 On consume with no simultaneous accept, out_valid SHALL clear to 0 and result outputs SHALL hold their last values.
REQ-026 On simultaneous consume and accept, out_valid SHALL stay 1 and the new result SHALL replace the old with no bubble; full throughput is one result per cycle.
REQ-027 While out_valid=1 and out_ready=0, all result outputs SHALL hold stable; in_ready=0 and in_valid is ignored.
REQ-028 choice=00: mux_out SHALL be mux_in[sel]; enc_out=0, enc_valid=0, dec_out=0.
REQ-029 choice=01: enc_out SHALL be the index of the highest set bit of enc_in, enc_valid=1; if enc_in=0, enc_out=0 and enc_valid=0; mux_out=0, dec_out=0.
REQ-030 choice=10: dec_out SHALL be one-hot with only bit dec_in set; mux_out=0, enc_out=0, enc_valid=0.
REQ-031 choice=11: dec_out SHALL contain only the highest set bit of enc_in (0 if enc_in=0), enc_out and enc_valid SHALL be as for choice=01; mux_out=0.
REQ-032 txn_count SHALL increment by 1 on every consume edge and saturate at all-ones.
REQ-033 Input fields not used by the selected choice SHALL not affect any output.

Reset
REQ-034 Asserting rst SHALL immediately, without a clock edge, force out_valid=0, out_choice=00, mux_out=0, enc_out=0, enc_valid=0, dec_out=0, txn_count=0.
REQ-035 in_ready SHALL read 1 while rst is asserted and after release; a result held when reset asserts SHALL be discarded and SHALL not be counted.
REQ-036 The first rising edge after rst deasserts SHALL accept a request if in_valid=1.

Verification
REQ-037 N=4, out_ready=1, choice=00, sweep {sel,mux_in} over all 64 values -> each next cycle mux_out=mux_in[sel], out_valid=1, txn_count reaches 64.
REQ-038 N=4, choice=01, enc_in=0001,0010,0100,1000,1011,0000 -> enc_out=0,1,2,3,3,0 with enc_valid=1,1,1,1,1,0.
REQ-039 N=8, choice=10, dec_in=0..7 then choice=11 with enc_in=0x5A -> dec_out=0x01..0x80, then dec_out=0x40, enc_out=6.
REQ-040 out_ready held 0 for 3 cycles with in_valid=1 and changing inputs -> first result stays stable, in_ready=0, txn_count unchanged; out_ready=1 -> back-to-back results, no loss or duplication.
REQ-041 rst asserted mid-clock-cycle while out_valid=1 -> out_valid and all outputs 0 before next edge; txn_count=0.
REQ-042 CNT_W=4, 20 consumes -> txn_count saturates at 15.

Source files
------------

// File: rtl/combo_pipe.sv
// Registered mux / priority-encoder / decoder / isolate-highest unit behind a
// one-deep valid/ready output register, with a saturating consumed-result counter.
module combo_pipe #(
    parameter int N     = 4,
    parameter int CNT_W = 16,
    localparam int W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       choice,
    input  logic [W-1:0]     sel,
    input  logic [N-1:0]     mux_in,
    input  logic [N-1:0]     enc_in,
    input  logic [W-1:0]     dec_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_choice,
    output logic             mux_out,
    output logic [W-1:0]     enc_out,
    output logic             enc_valid,
    output logic [N-1:0]     dec_out,
    output logic [CNT_W-1:0] txn_count
);

    logic             out_valid_q, out_valid_d;
    logic [1:0]       out_choice_q, out_choice_d;
    logic             mux_out_q, mux_out_d;
    logic [W-1:0]     enc_out_q, enc_out_d;
    logic             enc_valid_q, enc_valid_d;
    logic [N-1:0]     dec_out_q, dec_out_d;
    logic [CNT_W-1:0] txn_q, txn_d;

    logic             accept, consume;
    logic [W-1:0]     hi_idx;
    logic             hi_found;
    logic [N-1:0]     dec_onehot, hi_onehot;
    logic             res_mux, res_enc_valid;
    logic [W-1:0]     res_enc;
    logic [N-1:0]     res_dec;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        hi_idx   = '0;
        hi_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (enc_in[i]) begin
                hi_idx   = W'(i);
                hi_found = 1'b1;
            end
        end
    end

    always_comb begin
        dec_onehot         = '0;
        dec_onehot[dec_in] = 1'b1;
        hi_onehot          = '0;
        if (hi_found) hi_onehot[hi_idx] = 1'b1;
    end

    always_comb begin
        res_mux       = 1'b0;
        res_enc       = '0;
        res_enc_valid = 1'b0;
        res_dec       = '0;
        case (choice)
            2'b00: res_mux = mux_in[sel];
            2'b01: begin
                res_enc       = hi_idx;
                res_enc_valid = hi_found;
            end
            2'b10: res_dec = dec_onehot;
            default: begin
                res_enc       = hi_idx;
                res_enc_valid = hi_found;
                res_dec       = hi_onehot;
            end
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_choice_d = out_choice_q;
        mux_out_d    = mux_out_q;
        enc_out_d    = enc_out_q;
        enc_valid_d  = enc_valid_q;
        dec_out_d    = dec_out_q;
        txn_d        = txn_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_choice_d = choice;
            mux_out_d    = res_mux;
            enc_out_d    = res_enc;
            enc_valid_d  = res_enc_valid;
            dec_out_d    = res_dec;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
        if (consume && (txn_q != '1)) txn_d = txn_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_choice_q <= 2'b00;
            mux_out_q    <= 1'b0;
            enc_out_q    <= '0;
            enc_valid_q  <= 1'b0;
            dec_out_q    <= '0;
            txn_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_choice_q <= out_choice_d;
            mux_out_q    <= mux_out_d;
            enc_out_q    <= enc_out_d;
            enc_valid_q  <= enc_valid_d;
            dec_out_q    <= dec_out_d;
            txn_q        <= txn_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_choice = out_choice_q;
    assign mux_out    = mux_out_q;
    assign enc_out    = enc_out_q;
    assign enc_valid  = enc_valid_q;
    assign dec_out    = dec_out_q;
    assign txn_count  = txn_q;

endmodule

// File: tb/tb_combo_pipe.sv
// Directed bench for combo_pipe: an N=4/CNT_W=16 instance and an N=8/CNT_W=4
// instance share clock and reset; expectations are hand-computed.
module tb_combo_pipe;

    logic clk, rst;

    logic       iv4, ir4, ov4, or4, mux4, ev4;
    logic [1:0] ch4, och4, sel4, dsel4, enc4;
    logic [3:0] mi4, ei4, dec4;
    logic [15:0] txn4;

    logic       iv8, ir8, ov8, or8, mux8, ev8;
    logic [1:0] ch8, och8;
    logic [2:0] sel8, dsel8, enc8;
    logic [7:0] mi8, ei8, dec8;
    logic [3:0] txn8;

    int vectors = 0;
    int miscompares = 0;

    combo_pipe #(.N(4), .CNT_W(16)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .choice(ch4),
        .sel(sel4), .mux_in(mi4), .enc_in(ei4), .dec_in(dsel4),
        .out_valid(ov4), .out_ready(or4), .out_choice(och4), .mux_out(mux4),
        .enc_out(enc4), .enc_valid(ev4), .dec_out(dec4), .txn_count(txn4)
    );

    combo_pipe #(.N(8), .CNT_W(4)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .choice(ch8),
        .sel(sel8), .mux_in(mi8), .enc_in(ei8), .dec_in(dsel8),
        .out_valid(ov8), .out_ready(or8), .out_choice(och8), .mux_out(mux8),
        .enc_out(enc8), .enc_valid(ev8), .dec_out(dec8), .txn_count(txn8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] enc_tab   [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hB, 4'h0};
    logic [1:0] enc_exp   [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
    logic       encv_exp  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] hold_tab  [3] = '{2'd2, 2'd3, 2'd0};

    initial begin
        rst = 1'b1;
        iv4 = 1'b0; or4 = 1'b1; ch4 = 2'b00; sel4 = '0; mi4 = '0; ei4 = '0; dsel4 = '0;
        iv8 = 1'b0; or8 = 1'b1; ch8 = 2'b00; sel8 = '0; mi8 = '0; ei8 = '0; dsel8 = '0;
        #2;
        chk("rst_out_valid", ov4, 0);
        chk("rst_in_ready", ir4, 1);
        chk("rst_txn", txn4, 0);
        chk("rst_dec_out", dec4, 0);
        tick;
        tick;
        rst = 1'b0;

        // mux sweep on N=4; first edge after reset release accepts
        iv4 = 1'b1; or4 = 1'b1; ch4 = 2'b00;
        for (int v = 0; v < 64; v++) begin
            sel4 = v[5:4];
            mi4  = v[3:0];
            ei4  = 4'hF;
            dsel4 = 2'd3;
            tick;
            chk($sformatf("mux_out[%0d]", v), mux4, (v >> (v >> 4)) & 1);
            chk("mux_valid", ov4, 1);
            chk("mux_txn", txn4, v);
            if (v == 63) begin
                chk("mux_choice", och4, 0);
                chk("mux_enc_zero", {ev4, enc4}, 0);
                chk("mux_dec_zero", dec4, 0);
            end
        end
        iv4 = 1'b0;
        tick;
        chk("mux_txn_final", txn4, 64);
        chk("mux_drain_valid", ov4, 0);

        // priority encoder; mux fields set to ones must not leak
        iv4 = 1'b1; ch4 = 2'b01; sel4 = 2'd0; mi4 = 4'hF; dsel4 = 2'd2;
        for (int i = 0; i < 6; i++) begin
            ei4 = enc_tab[i];
            tick;
            chk($sformatf("enc_out[%0d]", i), enc4, enc_exp[i]);
            chk($sformatf("enc_valid[%0d]", i), ev4, encv_exp[i]);
            chk("enc_mux_zero", mux4, 0);
            chk("enc_dec_zero", dec4, 0);
            chk("enc_choice", och4, 1);
        end
        iv4 = 1'b0;
        tick;
        chk("enc_txn", txn4, 70);

        // backpressure: first result held for 3 cycles, then back-to-back
        or4 = 1'b0; iv4 = 1'b1; ch4 = 2'b10; dsel4 = 2'd1;
        tick;
        chk("bp_first_dec", dec4, 4'h2);
        chk("bp_in_ready", ir4, 0);
        for (int i = 0; i < 3; i++) begin
            dsel4 = hold_tab[i];
            ch4 = 2'(i + 1);
            tick;
            chk("bp_hold_dec", dec4, 4'h2);
            chk("bp_hold_choice", och4, 2);
            chk("bp_hold_ready", ir4, 0);
            chk("bp_hold_txn", txn4, 70);
        end
        or4 = 1'b1; ch4 = 2'b10; dsel4 = 2'd3;
        tick;
        chk("b2b_dec1", dec4, 4'h8);
        chk("b2b_txn1", txn4, 71);
        dsel4 = 2'd0;
        tick;
        chk("b2b_dec2", dec4, 4'h1);
        chk("b2b_valid2", ov4, 1);
        chk("b2b_txn2", txn4, 72);
        iv4 = 1'b0;
        tick;
        chk("b2b_drain_valid", ov4, 0);
        chk("b2b_drain_hold", dec4, 4'h1);
        chk("b2b_drain_txn", txn4, 73);

        // N=8 decoder then isolate-highest
        iv8 = 1'b1; or8 = 1'b1; ch8 = 2'b10; ei8 = 8'hFF; mi8 = 8'hFF; sel8 = 3'd7;
        for (int i = 0; i < 8; i++) begin
            dsel8 = 3'(i);
            tick;
            chk($sformatf("dec8[%0d]", i), dec8, 64'd1 << i);
            chk("dec8_enc_zero", {ev8, enc8, mux8}, 0);
        end
        ch8 = 2'b11; ei8 = 8'h5A; dsel8 = 3'd0;
        tick;
        chk("iso_dec", dec8, 8'h40);
        chk("iso_enc", enc8, 6);
        chk("iso_encv", ev8, 1);
        chk("iso_mux", mux8, 0);
        chk("iso_txn", txn8, 8);

        // saturation of the 4-bit counter
        ch8 = 2'b00;
        for (int k = 10; k <= 21; k++) begin
            tick;
            chk($sformatf("sat_txn[%0d]", k), txn8, (k - 1 > 15) ? 15 : k - 1);
        end
        iv8 = 1'b0;
        tick;
        chk("sat_final", txn8, 15);
        chk("sat_valid", ov8, 0);

        // asynchronous reset mid-cycle while a result is held
        iv4 = 1'b1; or4 = 1'b0; ch4 = 2'b00; sel4 = 2'd1; mi4 = 4'h2;
        tick;
        chk("arst_pre_valid", ov4, 1);
        chk("arst_pre_mux", mux4, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", ov4, 0);
        chk("arst_outs", {och4, mux4, enc4, ev4, dec4}, 0);
        chk("arst_txn", txn4, 0);
        chk("arst_in_ready", ir4, 1);
        tick;
        rst = 1'b0;
        iv4 = 1'b0;
        tick;
        chk("arst_after_txn", txn4, 0);
        chk("arst_after_valid", ov4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
